ifetch_unit: RTL
================

// Module: ifetch_unit
// PURPOSE
//   Instruction fetch sequencer sitting on both sides of the PC register.
//   Drives the PC register's next-value input and reads back its current value.
//   Issues req/ack reads to instruction memory and hands each fetched word to
//   decode over a valid/ready handshake. Applies branch/jump redirects and
//   squashes in-flight fetches. The PC register loads every clock, so this
//   block must drive pc_next = pc_cur whenever the PC is to hold.
// PARAMETERS
//   ADDR_W   32   PC / instruction-memory address width
//   DATA_W   32   instruction word width
//   PC_STEP  4    byte increment added to PC after each accepted fetch
// PORTS
//   clk             in   1       clock, rising-edge
//   rst             in   1       asynchronous reset, active-high
//   pc_cur          in   ADDR_W  current PC (PC register output)
//   pc_next         out  ADDR_W  next PC (PC register input), combinational
//   redirect_valid  in   1       branch/jump taken this cycle
//   redirect_pc     in   ADDR_W  redirect target
//   imem_req        out  1       memory read request
//   imem_addr       out  ADDR_W  memory read address
//   imem_ack        in   1       read data valid; may assert in the same cycle as req
//   imem_rdata      in   DATA_W  read data
//   inst_valid      out  1       fetched instruction available, registered
//   inst_ready      in   1       decode accepts instruction
//   inst_data       out  DATA_W  instruction word, registered
//   inst_pc         out  ADDR_W  PC of inst_data, registered
//   fault           out  1       misaligned-PC fault; see CONFIGURATION
// BEHAVIOUR
//   States: IDLE, FETCH, HOLD, DRAIN (plus HALT with the macro).
//   Reset: state=IDLE; inst_valid=0, inst_data=0, inst_pc=0, fault=0,
//     drain_addr=0. rst mid-operation abandons any request immediately.
//   Default (no case below applies): pc_next = pc_cur, imem_req=0, imem_addr=pc_cur.
//   IDLE: lasts 1 cycle after reset release -> FETCH.
//   FETCH: imem_req=1, imem_addr=pc_cur.
//     - ack & !redirect: inst_data<=imem_rdata, inst_pc<=pc_cur, inst_valid<=1,
//       pc_next=pc_cur+PC_STEP (wraps mod 2^ADDR_W) -> HOLD.
//     - ack & redirect: data discarded, pc_next=redirect_pc -> FETCH.
//     - !ack & redirect: drain_addr<=pc_cur, pc_next=redirect_pc -> DRAIN.
//     - !ack & !redirect: stay in FETCH; req and addr held stable.
//   DRAIN: imem_req=1, imem_addr=drain_addr. A request is never withdrawn
//     before ack. On ack: data discarded -> FETCH.
//     Redirect here: pc_next=redirect_pc; stay in DRAIN (last redirect wins).
//   HOLD: imem_req=0; inst_valid, inst_data and inst_pc held stable until
//     inst_valid & inst_ready.
//     - ready & !redirect: inst_valid<=0 -> FETCH.
//     - redirect (ready or not): inst_valid<=0, pc_next=redirect_pc -> FETCH.
//       The consumer's handshake, if any, still counts as a transfer.
//   Throughput: at most 1 instruction per 2 cycles (FETCH+HOLD, 0-wait memory).
//   Latency: req to inst_valid = ack cycle + 1.
//   redirect_valid always has priority over PC increment.
//   redirect_valid in IDLE: pc_next=redirect_pc, then the normal move to FETCH.
// CONFIGURATION
//   IFETCH_ALIGN_CHECK_EN defined:
//     - In FETCH with pc_cur[1:0]!=0: imem_req=0, fault<=1 -> HALT.
//     - HALT: no requests, pc_next=pc_cur, fault held at 1.
//     - redirect_valid in HALT: fault<=0, pc_next=redirect_pc -> FETCH.
//     - Redirect to a misaligned target re-faults on the next FETCH.
//   IFETCH_ALIGN_CHECK_EN undefined:
//     - fault tied 0; HALT state absent.
//     - Address low bits passed through unchecked.
// TESTING
//   1 rst pulse, pc=0, mem acks 1 cycle after req with 0xDEADBEEF
//     -> inst_valid=1, inst_data=0xDEADBEEF, inst_pc=0; pc_cur becomes 4.
//   2 inst_ready low 5 cycles in HOLD
//     -> inst_valid/data/pc stable, imem_req=0, pc_cur stays 4.
//     Ready high -> next req at 0x4.
//   3 redirect to 0x100 while in HOLD
//     -> inst_valid=0 next cycle; next imem_addr=0x100; pc_cur=0x100.
//   4 redirect to 0x200 in FETCH at 0x8, ack delayed 3 cycles
//     -> req held at addr 0x8 until ack, data never presented;
//     next req at 0x200.
//   5 rst asserted mid-FETCH with ack pending
//     -> imem_req=0, inst_valid=0, fault=0 asynchronously;
//     IDLE then FETCH at 0 after release.
//   6 (IFETCH_ALIGN_CHECK_EN) redirect to 0x102 -> fault=1, no req;
//     then redirect to 0x104 -> fault=0, req at 0x104.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch sequencer driving the PC register, imem req/ack and decode valid/ready.
// Optional misaligned-PC fault with HALT state when IFETCH_ALIGN_CHECK_EN is defined.
module ifetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fault
);
`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN, HALT} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
`endif
  state_t state, state_nx;
  logic [ADDR_W-1:0] drain_addr;
  logic load_inst, clr_inst, save_drain, set_fault, clr_fault, misaligned;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = pc_cur[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif
  always_comb begin
    state_nx   = state;
    pc_next    = pc_cur;
    imem_req   = 1'b0;
    imem_addr  = pc_cur;
    load_inst  = 1'b0;
    clr_inst   = 1'b0;
    save_drain = 1'b0;
    set_fault  = 1'b0;
    clr_fault  = 1'b0;
    case (state)
      IDLE: begin
        pc_next  = redirect_valid ? redirect_pc : pc_cur;
        state_nx = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          // A redirect overrides both the increment and any alignment fault.
          pc_next    = redirect_pc;
          imem_req   = !misaligned;
          save_drain = !misaligned && !imem_ack;
          state_nx   = (!misaligned && !imem_ack) ? DRAIN : FETCH;
        end else if (misaligned) begin
`ifdef IFETCH_ALIGN_CHECK_EN
          set_fault = 1'b1;
          state_nx  = HALT;
`endif
        end else begin
          imem_req  = 1'b1;
          load_inst = imem_ack;
          pc_next   = imem_ack ? pc_cur + ADDR_W'(PC_STEP) : pc_cur;
          state_nx  = imem_ack ? HOLD : FETCH;
        end
      end
      DRAIN: begin
        // Outstanding request stays asserted until memory acknowledges it.
        imem_req  = 1'b1;
        imem_addr = drain_addr;
        pc_next   = redirect_valid ? redirect_pc : pc_cur;
        state_nx  = imem_ack ? FETCH : DRAIN;
      end
      HOLD: begin
        pc_next  = redirect_valid ? redirect_pc : pc_cur;
        clr_inst = redirect_valid || inst_ready;
        state_nx = clr_inst ? FETCH : HOLD;
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      HALT: begin
        pc_next   = redirect_valid ? redirect_pc : pc_cur;
        clr_fault = redirect_valid;
        state_nx  = redirect_valid ? FETCH : HALT;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      drain_addr <= '0;
    end else begin
      state <= state_nx;
      if (load_inst) begin
        inst_valid <= 1'b1;
        inst_data  <= imem_rdata;
        inst_pc    <= pc_cur;
      end else if (clr_inst) begin
        inst_valid <= 1'b0;
      end
      if (save_drain) drain_addr <= pc_cur;
    end
  end
`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault <= 1'b0;
    else if (set_fault) fault <= 1'b1;
    else if (clr_fault) fault <= 1'b0;
  end
`else
  assign fault = 1'b0;
  logic unused;
  assign unused = set_fault | clr_fault;
`endif
endmodule
